// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : DLX MEM stage. Resolves branches toward IF, runs a req/ack
//               data-memory transaction with wait states and a timeout,
//               stalls upstream while an access is outstanding and drives
//               the registered MEM/WB outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        zero_in,
    input  logic [31:0] b_in,
    input  logic [31:0] npc_in,
    input  logic [31:0] aluoutput_in,
    input  logic [4:0]  rd_in,
    input  logic        branch_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [31:0] wb_lmd,
    output logic [31:0] wb_aluoutput,
    output logic [4:0]  wb_rd,
    output logic        bus_err
);

    // Explicitly encoded, 1-bit state register
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic             c_TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic w_mem_op;
    logic w_tmo_hit;
    logic w_issue;     // IDLE -> WAIT: launch the memory request
    logic w_pass;      // IDLE, no memory access: single-cycle pass-through
    logic w_complete;  // WAIT with ack: retire the memory instruction
    logic w_abort;     // WAIT timeout: squash the instruction
    logic w_unused;

    // npc is carried only for trace purposes; it does not affect this stage
    assign w_unused = ^npc_in;

    assign w_mem_op      = valid_in & (mem_read_in | mem_write_in);
    assign w_tmo_hit     = c_TMO_EN & (r_cnt == c_TMO_LAST);
    assign branch_target = aluoutput_in;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, stall and branch decision; ack takes priority over timeout
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        w_issue     = 1'b0;
        w_pass      = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        pc_src      = 1'b0;
        case (r_state)
            S_IDLE: begin
                pc_src = valid_in & branch_in & zero_in;
                if (w_mem_op) begin
                    stall       = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_pass = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Wait-cycle counter: cleared on issue, counts WAIT cycles without ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT && !dmem_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Memory interface, MEM/WB register and sticky bus error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_lmd        <= '0;
            wb_aluoutput  <= '0;
            wb_rd         <= '0;
            bus_err       <= 1'b0;
        end else if (w_pass) begin
            wb_valid      <= valid_in;
            wb_reg_write  <= valid_in & reg_write_in;
            wb_mem_to_reg <= mem_to_reg_in;
            wb_aluoutput  <= aluoutput_in;
            wb_rd         <= rd_in;
        end else if (w_issue) begin
            // A simultaneous read+write is treated as a write
            dmem_req     <= 1'b1;
            dmem_we      <= mem_write_in;
            dmem_addr    <= aluoutput_in;
            dmem_wdata   <= b_in;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end else if (w_complete) begin
            dmem_req      <= 1'b0;
            wb_valid      <= 1'b1;
            wb_reg_write  <= reg_write_in;
            wb_mem_to_reg <= mem_to_reg_in;
            wb_aluoutput  <= aluoutput_in;
            wb_rd         <= rd_in;
            if (!dmem_we) begin
                wb_lmd <= dmem_rdata;
            end
        end else if (w_abort) begin
            dmem_req     <= 1'b0;
            bus_err      <= 1'b1;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end else begin
            // Still waiting: keep emitting bubbles
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage with a
//               transaction-level reference model and a req/ack responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0, zero_in = 1'b0;
    logic [31:0] b_in = '0, npc_in = '0, aluoutput_in = '0;
    logic [4:0]  rd_in = '0;
    logic        branch_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic        reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
    logic        stall, pc_src, dmem_req, dmem_we;
    logic [31:0] branch_target, dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, bus_err;
    logic [31:0] wb_lmd, wb_aluoutput;
    logic [4:0]  wb_rd;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: last loaded data and sticky error
    logic [31:0] m_lmd = '0;
    logic        m_bus_err = 1'b0;

    mem_access_stage #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .zero_in(zero_in),
        .b_in(b_in), .npc_in(npc_in), .aluoutput_in(aluoutput_in), .rd_in(rd_in),
        .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_lmd(wb_lmd), .wb_aluoutput(wb_aluoutput), .wb_rd(wb_rd), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        valid_in = 0; zero_in = 0; b_in = '0; npc_in = '0; aluoutput_in = '0; rd_in = '0;
        branch_in = 0; mem_read_in = 0; mem_write_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
        dmem_ack = 0;
    endtask

    // Present one instruction, play the memory side, and compare the outcome
    // against what the instruction's rules predict. ack_delay = number of
    // WAIT cycles without ack before ack (negative = never ack).
    task automatic run_instr(input string name, input bit v, input bit br, input bit z,
                             input bit rdq, input bit wrq, input bit rw, input bit m2r,
                             input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rd,
                             input int ack_delay, input logic [31:0] rdata, input bit idle_ack);
        bit mem, tmo, done;
        int exp_cycles, n_stall, n_req, cyc;
        logic exp_pc;
        mem = v && (rdq || wrq);
        tmo = mem && (ack_delay < 0 || ack_delay >= T);
        exp_cycles = !mem ? 0 : (tmo ? T : ack_delay + 1);
        exp_pc = v & br & z;

        @(negedge clk);
        valid_in = v; branch_in = br; zero_in = z; mem_read_in = rdq; mem_write_in = wrq;
        reg_write_in = rw; mem_to_reg_in = m2r; aluoutput_in = alu; b_in = b; rd_in = rd;
        npc_in = $urandom();
        n_stall = 0; n_req = 0; cyc = 0; done = 0;
        while (!done) begin
            if (cyc > 0) @(negedge clk);
            dmem_ack   = idle_ack || (dmem_req && (n_req == ack_delay));
            dmem_rdata = (dmem_req && dmem_ack) ? rdata : $urandom();
            #1;
            if (cyc == 0) begin
                n_cmp++;
                if (pc_src !== exp_pc) begin
                    n_mis++; $display("FAIL %s pc_src: got %b expected %b", name, pc_src, exp_pc);
                end
                n_cmp++;
                if (branch_target !== alu) begin
                    n_mis++; $display("FAIL %s branch_target: got %h expected %h", name, branch_target, alu);
                end
            end
            if (dmem_req) begin
                n_req++;
                if (n_req == 1) begin
                    n_cmp++;
                    if (dmem_addr !== alu || dmem_we !== wrq || dmem_wdata !== b) begin
                        n_mis++;
                        $display("FAIL %s dmem_bus: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                                 name, dmem_addr, dmem_we, dmem_wdata, alu, wrq, b);
                    end
                end
            end
            if (stall) n_stall++;
            else done = 1;
            cyc++;
            if (cyc > 40) begin
                n_cmp++; n_mis++;
                $display("FAIL %s stall_bound: stall still high after %0d cycles expected release", name, cyc);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        dmem_ack = 0;

        if (mem && !tmo && !wrq) m_lmd = rdata;
        if (tmo) m_bus_err = 1'b1;

        n_cmp++;
        if (n_stall != exp_cycles) begin
            n_mis++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, n_stall, exp_cycles);
        end
        n_cmp++;
        if (n_req != exp_cycles) begin
            n_mis++; $display("FAIL %s req_cycles: got %0d expected %0d", name, n_req, exp_cycles);
        end
        n_cmp++;
        if (dmem_req !== 1'b0) begin
            n_mis++; $display("FAIL %s req_after: got %b expected 0", name, dmem_req);
        end
        n_cmp++;
        if (wb_valid !== (tmo ? 1'b0 : v)) begin
            n_mis++; $display("FAIL %s wb_valid: got %b expected %b", name, wb_valid, tmo ? 1'b0 : v);
        end
        if (!tmo) begin
            n_cmp++;
            if (wb_reg_write !== (v & rw) || wb_mem_to_reg !== m2r || wb_aluoutput !== alu || wb_rd !== rd) begin
                n_mis++;
                $display("FAIL %s wb_fields: got rw=%b m2r=%b alu=%h rd=%0d expected rw=%b m2r=%b alu=%h rd=%0d",
                         name, wb_reg_write, wb_mem_to_reg, wb_aluoutput, wb_rd, v & rw, m2r, alu, rd);
            end
        end
        n_cmp++;
        if (wb_lmd !== m_lmd) begin
            n_mis++; $display("FAIL %s wb_lmd: got %h expected %h", name, wb_lmd, m_lmd);
        end
        n_cmp++;
        if (bus_err !== m_bus_err) begin
            n_mis++; $display("FAIL %s bus_err: got %b expected %b", name, bus_err, m_bus_err);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({stall, pc_src, dmem_req, dmem_we, wb_valid, wb_reg_write, wb_mem_to_reg, bus_err} !== 8'h00 ||
            dmem_addr !== '0 || dmem_wdata !== '0 || wb_lmd !== '0 || wb_aluoutput !== '0 || wb_rd !== '0) begin
            n_mis++;
            $display("FAIL %s outputs: got stall=%b req=%b we=%b addr=%h wdata=%h wbv=%b lmd=%h alu=%h rd=%0d err=%b expected all 0",
                     name, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_lmd, wb_aluoutput, wb_rd, bus_err);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_alu();
        run_instr("alu", 1, 0, 0, 0, 0, 1, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0, 0);
    endtask

    task automatic test_load_wait3();
        run_instr("load3", 1, 0, 0, 1, 0, 1, 1, 32'h100, 32'h5555, 5'd7, 3, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_store_zero_wait();
        run_instr("store0", 1, 0, 0, 0, 1, 0, 0, 32'h200, 32'hCAFE_F00D, 5'd0, 0, 32'h1111_2222, 0);
    endtask

    task automatic test_read_write_both();
        run_instr("rdwr", 1, 0, 0, 1, 1, 0, 0, 32'h300, 32'h0BAD_F00D, 5'd3, 1, 32'h7777_7777, 0);
    endtask

    task automatic test_branch();
        run_instr("br_taken", 1, 1, 1, 0, 0, 0, 0, 32'h40, 32'h0, 5'd0, 0, 32'h0, 0);
        run_instr("br_nz", 1, 1, 0, 0, 0, 0, 0, 32'h44, 32'h0, 5'd0, 0, 32'h0, 0);
        run_instr("br_inv", 0, 1, 1, 0, 0, 0, 0, 32'h48, 32'h0, 5'd0, 0, 32'h0, 0);
    endtask

    task automatic test_idle_ack();
        run_instr("idle_ack", 1, 0, 0, 0, 0, 1, 0, 32'hABCD, 32'h0, 5'd9, 0, 32'h0, 1);
    endtask

    task automatic test_ack_at_limit();
        run_instr("ack16", 1, 0, 0, 1, 0, 1, 1, 32'h400, 32'h0, 5'd11, T - 1, 32'h1357_9BDF, 0);
    endtask

    task automatic test_timeout();
        run_instr("timeout", 1, 0, 0, 1, 0, 1, 1, 32'h500, 32'h0, 5'd12, -1, 32'h0, 0);
        run_instr("alu_after_tmo", 1, 0, 0, 0, 0, 1, 0, 32'h0000_9876, 32'h0, 5'd13, 0, 32'h0, 0);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        valid_in = 1; mem_read_in = 1; aluoutput_in = 32'h600; rd_in = 5'd14; reg_write_in = 1;
        repeat (3) @(posedge clk);
        #3;
        clear_inputs();
        reset = 0;
        #1;
        check_all_zero("reset_mid_wait");
        m_lmd = '0;
        m_bus_err = 1'b0;
        @(negedge clk);
        reset = 1;
        run_instr("alu_after_rst", 1, 0, 0, 0, 0, 1, 1, 32'h0000_4321, 32'h0, 5'd2, 0, 32'h0, 0);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            bit v, br, rdq, wrq;
            int r, d;
            v   = ($urandom_range(0, 7) != 0);
            br  = ($urandom_range(0, 4) == 0);
            r   = $urandom_range(0, 3);
            rdq = !br && (r == 1 || r == 3);
            wrq = !br && (r == 2 || r == 3);
            d   = $urandom_range(0, 11);
            if (d >= 10) d = -1;
            else d = d % 5;
            run_instr("random", v, br, 1'($urandom_range(0, 1)), rdq, wrq,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom(), $urandom(), 5'($urandom_range(0, 31)), d, $urandom(), 0);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait3();
        test_store_zero_wait();
        test_read_write_both();
        test_branch();
        test_idle_ack();
        test_ack_at_limit();
        test_timeout();
        test_reset_mid_wait();
        test_random(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the DLX pipeline. It is the consumer of the EX/MEM register outputs.
- Resolves branches: pc_src and branch_target go to IF.
- Runs a req/ack data-memory transaction with wait states and a timeout.
- Produces registered MEM/WB outputs.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles without dmem_ack before the access is aborted; 0 disables the timeout.
- CNT_W, 8: width of the wait-cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  EX/MEM holds a live instruction.
- zero_in  in  1  ALU zero flag.
- b_in  in  32  store data.
- npc_in  in  32  PC+4 (unused except for debug/trace).
- aluoutput_in  in  32  effective address / ALU result / branch target.
- rd_in  in  5  destination register.
- branch_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in  in  1 each  control bits.
- stall  out  1  hold EX/MEM and all earlier stages.
- pc_src  out  1  take branch.
- branch_target  out  32  branch destination.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  memory address.
- dmem_wdata  out  32  memory write data.
- dmem_rdata  in  32  memory read data, valid with dmem_ack.
- dmem_ack  in  1  memory completes the request this cycle.
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control.
- wb_lmd  out  32  load memory data.
- wb_aluoutput  out  32  ALU result.
- wb_rd  out  5  destination register.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - All registered outputs clear to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, all wb_* outputs, bus_err.
  - Reset mid-WAIT drops dmem_req immediately; the instruction is lost.
- mem_op = valid_in & (mem_read_in | mem_write_in). If both read and write are set, the access is a write.
- FSM states: IDLE, WAIT.
- IDLE, non-memory op or bubble:
  - Next edge: wb_valid <= valid_in, wb_reg_write <= valid_in & reg_write_in, wb_mem_to_reg, wb_aluoutput and wb_rd load from inputs.
  - wb_lmd holds. Latency is 1 cycle; stall = 0.
- IDLE, mem_op:
  - stall = 1 combinationally.
  - Next edge: dmem_req <= 1, dmem_we <= mem_write_in, dmem_addr <= aluoutput_in, dmem_wdata <= b_in, counter <= 0, state <= WAIT, wb_valid <= 0 (bubble).
- WAIT: dmem_req, dmem_we, dmem_addr and dmem_wdata are stable.
- WAIT with dmem_ack = 1:
  - stall = 0 in this cycle.
  - Next edge: dmem_req <= 0, state <= IDLE.
  - MEM/WB loads from the held EX/MEM inputs, with wb_valid = 1.
  - wb_lmd <= dmem_rdata if the access is a read; wb_lmd holds if it is a write.
  - Minimum memory-op latency is 2 cycles (ack in the first WAIT cycle).
- WAIT with dmem_ack = 0:
  - stall = 1; counter increments; wb_valid <= 0.
  - If TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: stall = 0 this cycle, and next edge dmem_req <= 0, bus_err <= 1, state <= IDLE, wb_valid <= 0. The instruction is squashed.
  - If ack and timeout occur in the same cycle, ack wins.
- dmem_ack while in IDLE is ignored.
- bus_err stays high until reset.
- Branch logic (combinational, IDLE only):
  - pc_src = valid_in & branch_in & zero_in & (state == IDLE).
  - branch_target = aluoutput_in.
  - Branches never issue memory requests.
- Upstream handling: upstream registers hold while stall = 1, so the inputs stay constant through WAIT.
- dmem_addr passes through unmodified, with no alignment checking.

Test Plan:
- Reset: drive reset=0 mid-run -> every output is 0 immediately, state IDLE, bus_err=0.
- ALU op: valid_in=1, aluoutput_in=0x00001234, rd_in=5, reg_write_in=1 -> next edge wb_valid=1, wb_aluoutput=0x1234, wb_rd=5, wb_reg_write=1; stall never asserts.
- Load with 3 wait cycles: aluoutput_in=0x100, mem_read_in=1, ack on the 4th WAIT cycle with dmem_rdata=0xDEADBEEF -> dmem_req high for 4 cycles, dmem_addr=0x100, dmem_we=0, stall high for 4 cycles, then wb_lmd=0xDEADBEEF and wb_valid=1 for one cycle.
- Zero-wait store: b_in=0xCAFEF00D, aluoutput_in=0x200, ack in the first WAIT cycle -> dmem_we=1, dmem_wdata=0xCAFEF00D, stall for exactly 1 cycle, wb_reg_write=0, wb_lmd unchanged.
- Branch: branch_in=1, zero_in=1, aluoutput_in=0x40 -> pc_src=1 and branch_target=0x40 in the same cycle; zero_in=0 -> pc_src=0; valid_in=0 -> pc_src=0.
- Timeout (TIMEOUT_CYCLES=16, ack never asserted) -> dmem_req high for 16 cycles then low, bus_err=1 (sticky), stall released, wb_valid=0. A following ALU op still completes normally. Ack on cycle 16 instead gives normal completion with bus_err=0.
